mastermind_round_sched: RTL

//  Round sequencer for the Mastermind datapath: turns the single LOAD button into per-slot

---
 rtl/mastermind_round_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mastermind_round_sched.sv
// Mastermind round sequencer: LOAD-button press edges become per-slot write strobes,
// then a 4-cycle peg-compare sweep, guess counting and WIN/LOSE. Optional: BTN_SYNC_EN.
module mastermind_round_sched #(
  parameter int MAX_GUESSES = 8,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_req,
  input  logic [2:0]       red_in,
  input  logic [2:0]       white_in,
  output logic [3:0]       load_code,
  output logic [3:0]       load_guess,
  output logic             clr_fb,
  output logic             compare_en,
  output logic [1:0]       compare_i,
  output logic [1:0]       slot,
  output logic [CNT_W-1:0] guess_num,
  output logic             result_valid,
  output logic             win,
  output logic             lose
);

  typedef enum logic [2:0] {S_CODE, S_GUESS, S_CMP, S_EVAL, S_WIN, S_LOSE} state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_GUESSES);

  logic btn;
  logic req_q;
  logic press;

`ifdef BTN_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (!resetn) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], load_req};
  end
  assign btn = sync_q[1];
`else
  assign btn = load_req;
`endif

  assign press = btn & ~req_q;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [1:0]       cmp_i_q, cmp_i_d;
  logic             cmp_en_q, cmp_en_d;
  logic [CNT_W-1:0] gnum_q, gnum_d, gnum_inc;
  logic             rv_q, rv_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;
  logic [3:0]       load_code_q, load_code_d;
  logic [3:0]       load_guess_q, load_guess_d;
  logic             clr_fb_q, clr_fb_d;
  logic [3:0]       slot_oh;

  assign slot_oh  = 4'b0001 << slot_q;
  assign gnum_inc = (gnum_q == MAX_C) ? gnum_q : gnum_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    cmp_i_d      = cmp_i_q;
    cmp_en_d     = cmp_en_q;
    gnum_d       = gnum_q;
    rv_d         = rv_q;
    win_d        = win_q;
    lose_d       = lose_q;
    load_code_d  = 4'b0000;
    load_guess_d = 4'b0000;
    clr_fb_d     = 1'b0;
    unique case (state_q)
      S_CODE: if (press) begin
        load_code_d = slot_oh;
        slot_d      = slot_q + 2'd1;
        if (slot_q == 2'd3) state_d = S_GUESS;
      end
      S_GUESS: if (press) begin
        load_guess_d = slot_oh;
        slot_d       = slot_q + 2'd1;
        // First guess slot of a round wipes the previous round's feedback
        if (slot_q == 2'd0) begin
          clr_fb_d = 1'b1;
          rv_d     = 1'b0;
        end
        if (slot_q == 2'd3) begin
          state_d  = S_CMP;
          cmp_en_d = 1'b1;
          cmp_i_d  = 2'd0;
        end
      end
      S_CMP: begin
        cmp_i_d = cmp_i_q + 2'd1;
        if (cmp_i_q == 2'd3) begin
          cmp_en_d = 1'b0;
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        // red_in now reflects the slot-3 compare registered at the end of CMP
        gnum_d = gnum_inc;
        rv_d   = 1'b1;
        slot_d = 2'd0;
        if (red_in == 3'd4) begin
          win_d   = 1'b1;
          state_d = S_WIN;
        end else if (gnum_inc == MAX_C) begin
          lose_d  = 1'b1;
          state_d = S_LOSE;
        end else begin
          state_d = S_GUESS;
        end
      end
      S_WIN, S_LOSE: if (press) begin
        clr_fb_d = 1'b1;
        gnum_d   = '0;
        rv_d     = 1'b0;
        win_d    = 1'b0;
        lose_d   = 1'b0;
        slot_d   = 2'd0;
        state_d  = S_CODE;
      end
      default: state_d = S_CODE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_CODE;
      req_q        <= 1'b0;
      slot_q       <= 2'd0;
      cmp_i_q      <= 2'd0;
      cmp_en_q     <= 1'b0;
      gnum_q       <= '0;
      rv_q         <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
      load_code_q  <= 4'b0000;
      load_guess_q <= 4'b0000;
      clr_fb_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= btn;
      slot_q       <= slot_d;
      cmp_i_q      <= cmp_i_d;
      cmp_en_q     <= cmp_en_d;
      gnum_q       <= gnum_d;
      rv_q         <= rv_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
      load_code_q  <= load_code_d;
      load_guess_q <= load_guess_d;
      clr_fb_q     <= clr_fb_d;
    end
  end

  assign load_code    = load_code_q;
  assign load_guess   = load_guess_q;
  assign clr_fb       = clr_fb_q;
  assign compare_en   = cmp_en_q;
  assign compare_i    = cmp_i_q;
  assign slot         = slot_q;
  assign guess_num    = gnum_q;
  assign result_valid = rv_q;
  assign win          = win_q;
  assign lose         = lose_q;

  logic unused_white;
  assign unused_white = ^white_in;

endmodule
